reg_bank_arbiter: RTL and testbench

- Round-robin arbiter that shares a bank of four 4-bit registers among NUM_REQ independent requesters.
- Each requester presents a request, a register address and write data. The arbiter issues a registered one-hot grant and commits the write into the addressed register.
- Optional lock lets a requester hold the bank for a bounded burst.
- Bank contents are exposed on a read port for downstream datapath use.

---
 rtl/reg_bank_arbiter.sv | 116 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing four 4-bit registers among NUM_REQ requesters.
// A granted requester may lock the bank for a burst of up to MAX_BURST commits.
module reg_bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     lock,
  input  logic [2*NUM_REQ-1:0]   addr,
  input  logic [4*NUM_REQ-1:0]   wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   wr_en,
  output logic [15:0]            bank_q,
  input  logic [1:0]             rd_addr,
  output logic [3:0]             rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  holder, next_holder;
  logic [IDX_W-1:0]  ptr, next_ptr;
  logic [IDX_W-1:0]  pick;
  logic [3:0]        cnt, next_cnt;
  logic [3:0]        bank [4];
  logic              found, do_arb, commit;
  logic [1:0]        commit_addr;
  logic [3:0]        commit_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      holder <= '0;
      ptr    <= '0;
      cnt    <= '0;
      wr_en  <= 1'b0;
      for (int k = 0; k < 4; k++) bank[k] <= 4'h0;
    end else begin
      state  <= next_state;
      holder <= next_holder;
      ptr    <= next_ptr;
      cnt    <= next_cnt;
      wr_en  <= commit;
      if (commit) bank[commit_addr] <= commit_data;
    end
  end

  // A commit needs the holder to still be requesting; a dropped req releases the grant.
  always_comb begin
    int idx;
    idx         = 0;
    commit      = (state != IDLE) && req[holder];
    commit_addr = addr[{holder, 1'b0} +: 2];
    commit_data = wdata[{holder, 2'b00} +: 4];

    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end

    next_state  = state;
    next_holder = holder;
    next_ptr    = ptr;
    next_cnt    = cnt;
    do_arb      = 1'b0;

    case (state)
      LOCKED: begin
        if (req[holder] && lock[holder] && (({1'b0, cnt} + 5'd1) < BURST_LIM))
          next_cnt = cnt + 4'd1;
        else
          do_arb = 1'b1;
      end
      GRANT: begin
        if (req[holder] && lock[holder] && (BURST_LIM > 5'd1)) begin
          next_state = LOCKED;
          next_cnt   = 4'd1;
        end else begin
          do_arb = 1'b1;
        end
      end
      default: do_arb = 1'b1;
    endcase

    // The pointer already sits just past the holder, so a forced burst exit demotes it.
    if (do_arb) begin
      next_cnt = 4'd0;
      if (found) begin
        next_state  = GRANT;
        next_holder = pick;
        next_ptr    = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
      end else begin
        next_state = IDLE;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state != IDLE) gnt[holder] = 1'b1;
    bank_q  = {bank[3], bank[2], bank[1], bank[0]};
    rd_data = bank[rd_addr];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Testbench for reg_bank_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and bank rules.
module tb_reg_bank_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [2*N-1:0] addr;
  logic [4*N-1:0] wdata;
  logic [N-1:0]  gnt;
  logic          wr_en;
  logic [15:0]   bank_q;
  logic [1:0]    rd_addr;
  logic [3:0]    rd_data;

  int compared;
  int mismatched;

  int         m_holder;
  int         m_ptr;
  int         m_cnt;
  bit         m_locked;
  logic [3:0] m_bank [4];
  logic       m_wr;

  reg_bank_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .wr_en(wr_en), .bank_q(bank_q),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_holder >= 0) g[m_holder] = 1'b1;
    return g;
  endfunction

  function automatic logic [15:0] m_bank_q();
    return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_locked = 0;
    m_wr     = 0;
    for (int k = 0; k < 4; k++) m_bank[k] = 4'h0;
  endtask

  // One clock edge worth of the arbitration rules, applied to the current inputs.
  task automatic model_step();
    int  h;
    bit  arb;
    h    = m_holder;
    m_wr = (h >= 0) && req[h];
    if (m_wr) m_bank[addr[2*h +: 2]] = wdata[4*h +: 4];
    arb = 1;
    if (m_locked) begin
      if (req[h] && lock[h] && (m_cnt + 1 < MB)) begin
        m_cnt = m_cnt + 1;
        arb   = 0;
      end
    end else if (h >= 0 && req[h] && lock[h] && MB > 1) begin
      m_locked = 1;
      m_cnt    = 1;
      arb      = 0;
    end
    if (arb) begin
      m_locked = 0;
      m_cnt    = 0;
      m_holder = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_holder < 0 && req[j]) begin
          m_holder = j;
          m_ptr    = (j + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; lock = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req = '1; lock = '0; addr = '0; wdata = '0;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      compared++;
      if (gnt !== 4'b0000 || wr_en !== 1'b0 || bank_q !== 16'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold: gnt=%b wr_en=%b bank_q=%h, need 0000/0/0000", gnt, wr_en, bank_q);
      end
    end
    reset = 1'b1;
    tick();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL reset_first_grant: gnt=%b, need 0001", gnt);
    end
  endtask

  task automatic test_single_writer();
    do_reset();
    req = 4'b0100;
    addr = 8'b00_01_00_00;
    wdata = 16'h0A00;
    tick();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL single_grant: gnt=%b, need 0100", gnt);
    end
    tick();
    rd_addr = 2'd1;
    #1;
    compared++;
    if (bank_q[7:4] !== 4'hA || wr_en !== 1'b1 || rd_data !== 4'hA) begin
      mismatched++;
      $display("[TB] FAIL single_commit: reg1=%h wr_en=%b rd_data=%h, need A/1/A", bank_q[7:4], wr_en, rd_data);
    end
    req = '0;
    tick();
    compared++;
    if (wr_en !== 1'b0 || gnt !== 4'b0000 || bank_q !== 16'h00A0) begin
      mismatched++;
      $display("[TB] FAIL single_release: wr_en=%b gnt=%b bank_q=%h, need 0/0000/00a0", wr_en, gnt, bank_q);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_seq [8];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      compared++;
      if (gnt !== exp_seq[c]) begin
        mismatched++;
        $display("[TB] FAIL fairness[%0d]: gnt=%b, need %b", c, gnt, exp_seq[c]);
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [N-1:0] exp_gnt [6];
    logic         exp_wr [6];
    exp_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
    exp_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    req  = 4'b1010;
    lock = 4'b0010;
    addr = 8'b11_00_10_00;
    wdata = 16'h3070;
    for (int c = 0; c < 6; c++) begin
      tick();
      compared++;
      if (gnt !== exp_gnt[c] || wr_en !== exp_wr[c]) begin
        mismatched++;
        $display("[TB] FAIL burst[%0d]: gnt=%b wr_en=%b, need %b/%b", c, gnt, wr_en, exp_gnt[c], exp_wr[c]);
      end
    end
    compared++;
    if (bank_q !== 16'h3700) begin
      mismatched++;
      $display("[TB] FAIL burst_bank: bank_q=%h, need 3700", bank_q);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b0011;
    addr = 8'b00_00_01_10;
    wdata = 16'h00FF;
    tick();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL drop_grant: gnt=%b, need 0001", gnt);
    end
    req = 4'b0010;
    tick();
    compared++;
    if (gnt !== 4'b0010 || wr_en !== 1'b0 || bank_q !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL drop_no_write: gnt=%b wr_en=%b bank_q=%h, need 0010/0/0000", gnt, wr_en, bank_q);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1000;
    lock = 4'b1000;
    addr = 8'b11_00_00_00;
    wdata = 16'h5000;
    repeat (3) tick();
    compared++;
    if (bank_q[15:12] !== 4'h5 || gnt !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL midburst_pre: reg3=%h gnt=%b, need 5/1000", bank_q[15:12], gnt);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compared++;
    if (bank_q !== 16'h0 || gnt !== 4'b0000 || wr_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midburst_async: bank_q=%h gnt=%b wr_en=%b, need 0000/0000/0", bank_q, gnt, wr_en);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 4'b1111;
    lock = '0;
    tick();
    compared++;
    if (gnt !== 4'b0001 || bank_q !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL midburst_restart: gnt=%b bank_q=%h, need 0001/0000", gnt, bank_q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req     = N'($urandom);
      lock    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      addr    = (2*N)'($urandom);
      wdata   = (4*N)'($urandom);
      rd_addr = 2'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        compared++;
        if (bank_q !== 16'h0 || gnt !== 4'b0000) begin
          mismatched++;
          $display("[TB] FAIL rand_reset[%0d]: bank_q=%h gnt=%b, need 0000/0000", c, bank_q, gnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        tick();
        compared++;
        if (gnt !== m_gnt() || wr_en !== m_wr || bank_q !== m_bank_q()) begin
          mismatched++;
          $display("[TB] FAIL rand[%0d]: gnt=%b wr_en=%b bank_q=%h, need %b/%b/%h",
                   c, gnt, wr_en, bank_q, m_gnt(), m_wr, m_bank_q());
        end
        compared++;
        if (rd_data !== m_bank[rd_addr]) begin
          mismatched++;
          $display("[TB] FAIL rand_read[%0d]: rd_data=%h, need %h", c, rd_data, m_bank[rd_addr]);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset   = 1'b0;
    req     = '0;
    lock    = '0;
    addr    = '0;
    wdata   = '0;
    rd_addr = '0;
    model_reset();
    test_reset();
    test_single_writer();
    test_fairness();
    test_burst_limit();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
